// File: rtl/axil_arb_pkg.sv
// ---------------------------------------------------------------------------
// axil_arb_pkg
//   Shared types and constants for the AXI-Lite write arbiter:
//     arb_state_e  - arbiter FSM states (IDLE / WAIT / GAP)
//     RESP_*       - AXI write response codes used by the arbiter
//     DEF_*_W      - default address / data widths
//     idx_w()      - index width for a vector of n entries (never below 1)
// ---------------------------------------------------------------------------
package axil_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Width needed to hold an index 0..n-1; a one-entry vector still gets a
  // one-bit index so no port collapses to zero width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : axil_arb_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin selector. Searches the request vector
//   starting at rr_ptr and wrapping modulo N; the first set bit wins. The
//   pointer itself is owned by the caller.
//
//   Ports:
//     req        in  N    request vector
//     rr_ptr     in  IW   index searched first
//     grant_idx  out IW   winning index (rr_ptr when nothing is requesting)
//     any_req    out 1    at least one request bit is set
// ---------------------------------------------------------------------------
module rr_arbiter
  import axil_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  logic          found;
  logic [IW-1:0] cand_idx;

  // NOTE: every variable written in an always_comb gets a default at the top
  // of the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant_idx = rr_ptr;
    any_req   = |req;
    found     = 1'b0;
    cand_idx  = '0;
    for (int i = 0; i < N; i++) begin
      cand_idx = IW'((int'(rr_ptr) + i) % N);
      if (!found && req[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/axil_wr_arbiter.sv
// ---------------------------------------------------------------------------
// axil_wr_arbiter
//   Shares one AXI-Lite write master between N_REQ requesters. Grants are
//   round-robin with a single write outstanding. o_wr is held until the
//   master's write response rises (or a WAIT-state timeout expires), after
//   which o_wr is forced low for at least GAP_CYCLES cycles and until the
//   master has dropped i_bvalid.
//
//   Ports:
//     m_axi_aclk     in   1               clock
//     m_axi_aresetn  in   1               synchronous active-low reset
//     req_valid      in   N_REQ           per-requester write request
//     req_addr       in   N_REQ*ADDR_W    requester k at [k*ADDR_W +: ADDR_W]
//     req_data       in   N_REQ*DATA_W    requester k at [k*DATA_W +: DATA_W]
//     req_strb       in   N_REQ*STRB_W    requester k at [k*STRB_W +: STRB_W]
//     req_ack        out  N_REQ           pulse: request captured
//     req_done       out  N_REQ           pulse: write completed or abandoned
//     req_resp       out  2               BRESP (or SLVERR on timeout) with req_done
//     o_wr           out  1               master write command
//     o_addrin       out  ADDR_W          master write address
//     o_din          out  DATA_W          master write data
//     o_strb         out  STRB_W          master byte strobes
//     i_bvalid       in   1               master write-response valid
//     i_bresp        in   2               master write response
//     o_busy         out  1               FSM outside IDLE
//     o_timeout      out  1               pulse: write abandoned
// ---------------------------------------------------------------------------
module axil_wr_arbiter
  import axil_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TIMEOUT    = 256,
  parameter int GAP_CYCLES = 1
) (
  input  logic                        m_axi_aclk,
  input  logic                        m_axi_aresetn,

  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_W-1:0]     req_addr,
  input  logic [N_REQ*DATA_W-1:0]     req_data,
  input  logic [N_REQ*(DATA_W/8)-1:0] req_strb,
  output logic [N_REQ-1:0]            req_ack,
  output logic [N_REQ-1:0]            req_done,
  output logic [1:0]                  req_resp,

  output logic                        o_wr,
  output logic [ADDR_W-1:0]           o_addrin,
  output logic [DATA_W-1:0]           o_din,
  output logic [DATA_W/8-1:0]         o_strb,
  input  logic                        i_bvalid,
  input  logic [1:0]                  i_bresp,

  output logic                        o_busy,
  output logic                        o_timeout
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IW     = idx_w(N_REQ);
  localparam int TW     = idx_w(TIMEOUT);
  localparam int GW     = idx_w(GAP_CYCLES);

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] PTR_LAST = IW'(N_REQ - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  arb_state_e          state_q,   state_d;
  logic [IW-1:0]       rr_ptr_q,  rr_ptr_d;
  logic [IW-1:0]       grant_q,   grant_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [DATA_W-1:0]   data_q,    data_d;
  logic [STRB_W-1:0]   strb_q,    strb_d;
  logic                wr_q,      wr_d;
  logic [N_REQ-1:0]    ack_q,     ack_d;
  logic [N_REQ-1:0]    done_q,    done_d;
  logic [1:0]          resp_q,    resp_d;
  logic                timeout_q, timeout_d;
  logic [TW-1:0]       to_cnt_q,  to_cnt_d;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
  logic                bvalid_q,  bvalid_d;

  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic                b_rise;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Only a fresh rising edge of bvalid counts as the response for the write
  // in flight; a level left over from a previous write is ignored.
  assign b_rise = i_bvalid & ~bvalid_q;

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    wr_d      = wr_q;
    ack_d     = '0;
    done_d    = '0;
    resp_d    = RESP_OKAY;
    timeout_d = 1'b0;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    bvalid_d  = i_bvalid;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d        = arb_idx;
          addr_d         = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
          data_d         = req_data[int'(arb_idx)*DATA_W +: DATA_W];
          strb_d         = req_strb[int'(arb_idx)*STRB_W +: STRB_W];
          rr_ptr_d       = (arb_idx == PTR_LAST) ? '0 : arb_idx + IW'(1);
          ack_d[arb_idx] = 1'b1;
          wr_d           = 1'b1;
          to_cnt_d       = '0;
          state_d        = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // A response arriving on the final timeout cycle still wins.
        if (b_rise) begin
          wr_d            = 1'b0;
          done_d[grant_q] = 1'b1;
          resp_d          = i_bresp;
          gap_cnt_d       = '0;
          state_d         = ST_GAP;
        end else if (to_cnt_q == TO_LAST) begin
          wr_d            = 1'b0;
          done_d[grant_q] = 1'b1;
          resp_d          = RESP_SLVERR;
          timeout_d       = 1'b1;
          gap_cnt_d       = '0;
          state_d         = ST_GAP;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      ST_GAP: begin
        // gap_cnt_q counts completed GAP cycles minus one and saturates, so
        // a master that keeps bvalid high parks the FSM here indefinitely.
        if (gap_cnt_q >= GAP_LAST && !i_bvalid) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q < GAP_LAST) begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        wr_d    = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of the others, independent of the order
  // in which the statements are written.
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      // NOTE: the payload registers are reset too, even though they only
      // matter while o_wr is high, because they drive module outputs that
      // must read zero out of reset.
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      wr_q      <= 1'b0;
      ack_q     <= '0;
      done_q    <= '0;
      resp_q    <= RESP_OKAY;
      timeout_q <= 1'b0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      bvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      wr_q      <= wr_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_wr      = wr_q;
  assign o_addrin  = addr_q;
  assign o_din     = data_q;
  assign o_strb    = strb_q;
  assign req_ack   = ack_q;
  assign req_done  = done_q;
  assign req_resp  = resp_q;
  assign o_timeout = timeout_q;
  assign o_busy    = (state_q != ST_IDLE);

endmodule : axil_wr_arbiter

// File: tb/tb_axil_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axil_wr_arbiter
//   Directed bench for axil_wr_arbiter (N_REQ=2, TIMEOUT=16, GAP_CYCLES=1).
//   The stimulus process pushes the hand-computed grants and completions
//   into two queues; an independent monitor pops them whenever the DUT
//   pulses req_ack or req_done and compares.
// ---------------------------------------------------------------------------
module tb_axil_wr_arbiter;

  localparam int N_REQ      = 2;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STRB_W     = DATA_W / 8;
  localparam int TIMEOUT    = 16;
  localparam int GAP_CYCLES = 1;

  localparam int K_ACK  = 0;
  localparam int K_DONE = 1;
  localparam int K_IDLE = 2;

  logic                    clk    = 1'b0;
  logic                    rst_n  = 1'b0;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr  = '0;
  logic [N_REQ*DATA_W-1:0] req_data  = '0;
  logic [N_REQ*STRB_W-1:0] req_strb  = '0;
  logic [N_REQ-1:0]        req_ack;
  logic [N_REQ-1:0]        req_done;
  logic [1:0]              req_resp;
  logic                    o_wr;
  logic [ADDR_W-1:0]       o_addrin;
  logic [DATA_W-1:0]       o_din;
  logic [STRB_W-1:0]       o_strb;
  logic                    i_bvalid = 1'b0;
  logic [1:0]              i_bresp  = 2'b00;
  logic                    o_busy;
  logic                    o_timeout;

  always #5 clk = ~clk;

  axil_wr_arbiter #(
    .N_REQ      (N_REQ),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .TIMEOUT    (TIMEOUT),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_strb      (req_strb),
    .req_ack       (req_ack),
    .req_done      (req_done),
    .req_resp      (req_resp),
    .o_wr          (o_wr),
    .o_addrin      (o_addrin),
    .o_din         (o_din),
    .o_strb        (o_strb),
    .i_bvalid      (i_bvalid),
    .i_bresp       (i_bresp),
    .o_busy        (o_busy),
    .o_timeout     (o_timeout)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  typedef struct {
    int              idx;
    logic [31:0]     addr;
    logic [31:0]     data;
    logic [3:0]      strb;
  } wr_exp_t;

  typedef struct {
    int              idx;
    logic [1:0]      resp;
    logic            to;
  } done_exp_t;

  wr_exp_t   wr_exp_q[$];
  done_exp_t done_exp_q[$];
  wr_exp_t   we;
  done_exp_t de;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  int   low_cnt = 100;
  logic prev_wr = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ack != '0) begin
        if (wr_exp_q.size() == 0) begin
          check("unexpected_ack", 64'(req_ack), 64'(0));
        end else begin
          we = wr_exp_q.pop_front();
          check("ack_idx",  64'(req_ack),  64'(1 << we.idx));
          check("wr_addr",  64'(o_addrin), 64'(we.addr));
          check("wr_data",  64'(o_din),    64'(we.data));
          check("wr_strb",  64'(o_strb),   64'(we.strb));
          check("wr_rise_with_ack", 64'({prev_wr, o_wr}), 64'(2'b01));
          check("wr_gap_len", 64'(low_cnt >= GAP_CYCLES), 64'(1));
        end
      end else if (o_wr && !prev_wr) begin
        check("wr_without_ack", 64'(1), 64'(0));
      end

      if (req_done != '0 || o_timeout) begin
        if (done_exp_q.size() == 0) begin
          check("unexpected_done", 64'({req_done, o_timeout}), 64'(0));
        end else begin
          de = done_exp_q.pop_front();
          check("done_idx",     64'(req_done),  64'(1 << de.idx));
          check("done_resp",    64'(req_resp),  64'(de.resp));
          check("done_timeout", 64'(o_timeout), 64'(de.to));
          check("done_wr_low",  64'(o_wr),      64'(0));
        end
      end
    end
    low_cnt = o_wr ? 0 : low_cnt + 1;
    prev_wr = o_wr;
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    req_addr[k*ADDR_W +: ADDR_W] = a;
    req_data[k*DATA_W +: DATA_W] = d;
    req_strb[k*STRB_W +: STRB_W] = s;
    req_valid[k]                 = 1'b1;
  endtask

  task automatic push_wr(input int k, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    wr_exp_q.push_back('{idx: k, addr: a, data: d, strb: s});
  endtask

  task automatic push_done(input int k, input logic [1:0] r, input logic t);
    done_exp_q.push_back('{idx: k, resp: r, to: t});
  endtask

  function automatic int ack_idx();
    for (int k = 0; k < N_REQ; k++) if (req_ack[k]) return k;
    return 0;
  endfunction

  // Waits (bounded) for a DUT event; n = falling edges until it was seen.
  task automatic wait_for(input int kind, input int budget, input string name, output int n);
    logic hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (kind)
        K_ACK:   hit = (req_ack != '0);
        K_DONE:  hit = (req_done != '0);
        K_IDLE:  hit = !o_busy;
        default: hit = 1'b1;
      endcase
    end
    check({name, "_seen"}, 64'(hit), 64'(1));
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check({name, "_ctrl"}, 64'({o_wr, o_busy, o_timeout, req_ack, req_done, req_resp, o_strb}), 64'(0));
    check({name, "_payload"}, {o_addrin, o_din}, 64'(0));
    rst_n = 1'b1;
  endtask

  // Raise bvalid one cycle from now with the given response; expect done
  // on the following falling edge, then release bvalid.
  task automatic complete(input logic [1:0] resp, input string name);
    int n;
    @(negedge clk);
    i_bresp  = resp;
    i_bvalid = 1'b1;
    wait_for(K_DONE, 8, name, n);
    check({name, "_done_lat"}, 64'(n), 64'(1));
    i_bvalid = 1'b0;
    i_bresp  = 2'b00;
  endtask

  // -------------------------------------------------------------------------
  // Directed tests
  // -------------------------------------------------------------------------
  initial begin
    int n;
    int k;
    logic [31:0] ra [N_REQ];
    logic [31:0] rd [N_REQ];
    logic [3:0]  rs [N_REQ];

    do_reset("reset0");

    // T1: single request, response 5 cycles after the ack.
    push_wr(0, 32'h10, 32'h7, 4'hF);
    push_done(0, 2'b00, 1'b0);
    set_req(0, 32'h10, 32'h7, 4'hF);
    wait_for(K_ACK, 8, "t1_ack", n);
    check("t1_ack_lat", 64'(n), 64'(1));
    req_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("t1_wr_held", 64'(o_wr), 64'(1));
    i_bvalid = 1'b1;
    wait_for(K_DONE, 8, "t1_done", n);
    check("t1_done_lat", 64'(n), 64'(1));
    i_bvalid = 1'b0;
    wait_for(K_IDLE, 8, "t1_idle", n);
    check("t1_gap_to_idle", 64'(n), 64'(1));

    // T2: both requesters from reset, each re-requests on done.
    do_reset("reset1");
    ra[0] = 32'h4; rd[0] = 32'h11; rs[0] = 4'hF;
    ra[1] = 32'h8; rd[1] = 32'h22; rs[1] = 4'h3;
    for (int i = 0; i < 4; i++) begin
      push_wr(i % 2, ra[i % 2], rd[i % 2], rs[i % 2]);
      push_done(i % 2, 2'b00, 1'b0);
    end
    set_req(0, ra[0], rd[0], rs[0]);
    set_req(1, ra[1], rd[1], rs[1]);
    for (int i = 0; i < 4; i++) begin
      wait_for(K_ACK, 8, "t2_ack", n);
      check("t2_ack_lat", 64'(n), 64'((i == 0) ? 1 : 2));
      k = ack_idx();
      req_valid[k] = 1'b0;
      complete(2'b00, "t2");
      if (i < 2) set_req(k, ra[k], rd[k], rs[k]);
    end

    // T3: no response; r0 times out, then pending r1 proceeds.
    push_wr(0, 32'h30, 32'hA5A5_A5A5, 4'h1);
    push_done(0, 2'b10, 1'b1);
    push_wr(1, 32'h34, 32'h0000_005A, 4'h8);
    push_done(1, 2'b00, 1'b0);
    set_req(0, 32'h30, 32'hA5A5_A5A5, 4'h1);
    set_req(1, 32'h34, 32'h0000_005A, 4'h8);
    wait_for(K_ACK, 8, "t3_ack0", n);
    req_valid[0] = 1'b0;
    wait_for(K_DONE, 40, "t3_timeout", n);
    check("t3_wait_cycles", 64'(n), 64'(TIMEOUT));
    wait_for(K_ACK, 8, "t3_ack1", n);
    check("t3_ack1_lat", 64'(n), 64'(2));
    req_valid[1] = 1'b0;
    complete(2'b00, "t3");
    wait_for(K_IDLE, 8, "t3_idle", n);

    // T4: bvalid already high on WAIT entry; only the second rise counts.
    push_wr(0, 32'h40, 32'h0000_1234, 4'hF);
    push_done(0, 2'b10, 1'b0);
    i_bvalid = 1'b1;
    i_bresp  = 2'b00;
    set_req(0, 32'h40, 32'h0000_1234, 4'hF);
    wait_for(K_ACK, 8, "t4_ack", n);
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    i_bvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_still_waiting", 64'({o_wr, req_done}), 64'({1'b1, 2'b00}));
    complete(2'b10, "t4");
    wait_for(K_IDLE, 8, "t4_idle", n);

    // T5: bvalid stuck high after completion parks the FSM in GAP.
    push_wr(1, 32'h50, 32'h0000_BEEF, 4'h3);
    push_done(1, 2'b00, 1'b0);
    push_wr(0, 32'h54, 32'h0000_CAFE, 4'hC);
    push_done(0, 2'b00, 1'b0);
    set_req(1, 32'h50, 32'h0000_BEEF, 4'h3);
    wait_for(K_ACK, 8, "t5_ack1", n);
    req_valid[1] = 1'b0;
    set_req(0, 32'h54, 32'h0000_CAFE, 4'hC);
    @(negedge clk);
    i_bvalid = 1'b1;
    wait_for(K_DONE, 8, "t5_done1", n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_parked", 64'({o_wr, o_busy, req_ack}), 64'({1'b0, 1'b1, 2'b00}));
    end
    i_bvalid = 1'b0;
    wait_for(K_ACK, 8, "t5_ack0", n);
    check("t5_ack0_lat", 64'(n), 64'(2));
    req_valid[0] = 1'b0;
    complete(2'b00, "t5");
    wait_for(K_IDLE, 8, "t5_idle", n);

    // T6: reset two cycles into WAIT drops the write; pointer restarts at 0.
    push_wr(1, 32'h64, 32'h0000_1111, 4'hF);
    push_wr(0, 32'h60, 32'h0000_600D, 4'hF);
    push_done(0, 2'b00, 1'b0);
    push_wr(1, 32'h64, 32'h0000_1111, 4'hF);
    push_done(1, 2'b00, 1'b0);
    set_req(0, 32'h60, 32'h0000_600D, 4'hF);
    set_req(1, 32'h64, 32'h0000_1111, 4'hF);
    wait_for(K_ACK, 8, "t6_ack_pre", n);
    do_reset("t6_reset");
    wait_for(K_ACK, 8, "t6_ack0", n);
    check("t6_ack0_lat", 64'(n), 64'(1));
    req_valid[ack_idx()] = 1'b0;
    complete(2'b00, "t6a");
    wait_for(K_ACK, 8, "t6_ack1", n);
    check("t6_ack1_lat", 64'(n), 64'(2));
    req_valid[ack_idx()] = 1'b0;
    complete(2'b00, "t6b");
    wait_for(K_IDLE, 8, "t6_idle", n);

    repeat (3) @(negedge clk);
    check("wr_queue_empty",   64'(wr_exp_q.size()),   64'(0));
    check("done_queue_empty", 64'(done_exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_axil_wr_arbiter
